// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures the period of a divided clock in CLK_IN1 cycles
// and reports lock/error status. Optional duty check: define DUTY_CHECK_EN.
module clk_ratio_monitor #(
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             CLK_IN1,
  input  logic             RESET,
  input  logic             MON_IN,
  output logic             LOCKED,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             ERR,
  output logic             DUTY_ERR
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int LO_I = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;

  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] P_LO  = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] P_HI  = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [GW-1:0]    G_MAX = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCK    = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic s1;
  logic s2;
  logic s_prev;
  logic rise;

  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_q;
  logic [GW-1:0]    good_d;
  logic [GW-1:0]    good_inc;
  logic [CNT_W-1:0] period_d;
  logic             pv_d;
  logic             err_d;
  logic             derr_d;
  logic             period_ok;
  logic             duty_bad;
  logic             bad;

  // MON_IN is asynchronous: two-stage synchroniser plus history flop
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= MON_IN;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  assign rise = s2 & ~s_prev;

  // Period counter: restarts at 1 on each rise, saturates at TIMEOUT
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt < T_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign period_ok = (cnt >= P_LO) && (cnt <= P_HI);

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W:0] DUTY_LIM = (CNT_W + 1)'(2 * TOL + 1);

  logic             fall;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W:0]   twice_h;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   diff;

  assign fall = ~s2 & s_prev;

  // High-time counter, latched on the falling edge of the monitored clock
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      hcnt   <= '0;
      high_q <= '0;
    end else begin
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (hcnt < T_MAX) begin
        hcnt <= hcnt + 1'b1;
      end
      if (fall) begin
        high_q <= hcnt;
      end
    end
  end

  // Duty error when twice the high time strays from the full period
  always_comb begin
    twice_h = {high_q, 1'b0};
    cnt_x   = {1'b0, cnt};
    diff    = '0;
    if (twice_h >= cnt_x) begin
      diff = twice_h - cnt_x;
    end else begin
      diff = cnt_x - twice_h;
    end
    duty_bad = (diff > DUTY_LIM);
  end
`else
  assign duty_bad = 1'b0;
`endif

  assign bad = ~period_ok | duty_bad;

  assign good_inc = (good_q < G_MAX) ? good_q + 1'b1 : good_q;

  // Next-state and registered-output values for the lock FSM
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = PERIOD;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    derr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d = cnt;
          pv_d     = 1'b1;
          if (bad) begin
            good_d = '0;
            err_d  = 1'b1;
            derr_d = duty_bad;
          end else begin
            good_d = good_inc;
            if (good_inc == G_MAX) begin
              state_d = ST_LOCK;
            end
          end
        end else if (cnt == T_MAX) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (rise) begin
          period_d = cnt;
          pv_d     = 1'b1;
          if (bad) begin
            good_d  = '0;
            err_d   = 1'b1;
            derr_d  = duty_bad;
            state_d = ST_MEASURE;
          end
        end else if (cnt == T_MAX) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        good_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, good-period count and registered status outputs
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      good_q       <= '0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      ERR          <= 1'b0;
      LOCKED       <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      PERIOD       <= period_d;
      PERIOD_VALID <= pv_d;
      ERR          <= err_d;
      LOCKED       <= (state_d == ST_LOCK);
    end
  end

`ifdef DUTY_CHECK_EN
  // Duty error pulse, aligned with the ERR pulse of the same rise
  always_ff @(posedge CLK_IN1) begin
    if (RESET) begin
      DUTY_ERR <= 1'b0;
    end else begin
      DUTY_ERR <= derr_d;
    end
  end
`else
  assign DUTY_ERR = derr_d & 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb_clk_ratio_monitor: directed checks of clk_ratio_monitor,
// default instance (TOL=0) and a TOL=1 instance.
module tb_clk_ratio_monitor;

  logic        clk;
  logic        rst;
  logic        mon0;
  logic        mon1;
  logic        locked0;
  logic        locked1;
  logic [15:0] period0;
  logic [15:0] period1;
  logic        pv0;
  logic        pv1;
  logic        err0;
  logic        err1;
  logic        derr0;
  logic        derr1;

  int n_tests;
  int n_fail;
  int cyc;
  int n_pv0;
  int n_err0;
  int n_derr0;
  int pv_cyc0;
  int pv_gap0;
  int err_cyc0;
  int n_pv1;
  int n_err1;
  int n_derr1;

  clk_ratio_monitor u0 (
    .CLK_IN1      (clk),
    .RESET        (rst),
    .MON_IN       (mon0),
    .LOCKED       (locked0),
    .PERIOD       (period0),
    .PERIOD_VALID (pv0),
    .ERR          (err0),
    .DUTY_ERR     (derr0)
  );

  clk_ratio_monitor #(.TOL(1)) u1 (
    .CLK_IN1      (clk),
    .RESET        (rst),
    .MON_IN       (mon1),
    .LOCKED       (locked1),
    .PERIOD       (period1),
    .PERIOD_VALID (pv1),
    .ERR          (err1),
    .DUTY_ERR     (derr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0; n_pv0 = 0; n_err0 = 0; n_derr0 = 0;
    pv_cyc0 = 0; pv_gap0 = 0; err_cyc0 = 0;
    n_pv1 = 0; n_err1 = 0; n_derr1 = 0;
  end

  // Pulse monitor: outputs sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pv0) begin
      pv_gap0 = cyc - pv_cyc0;
      pv_cyc0 = cyc;
      n_pv0++;
    end
    if (err0) begin
      n_err0++;
      err_cyc0 = cyc;
    end
    if (derr0) n_derr0++;
    if (pv1) n_pv1++;
    if (err1) n_err1++;
    if (derr1) n_derr1++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One monitored period: high for h cycles, low for p-h cycles
  task automatic wave0(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      mon0 = (i < h);
    end
  endtask

  task automatic wave1(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      mon1 = (i < h);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d;
    int p;
    int t;
    int exp_de;
    n_tests = 0;
    n_fail  = 0;
`ifdef DUTY_CHECK_EN
    exp_de = 1;
`else
    exp_de = 0;
`endif
    rst  = 1'b1;
    mon0 = 1'b0;
    mon1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked0), 0);
    check("rst_period", 32'(period0), 0);
    check("rst_pv", 32'(pv0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_derr", 32'(derr0), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (4) wave0(8, 4);
    check("prelock_locked", 32'(locked0), 0);
    check("prelock_pvcnt", 32'(n_pv0), 3);
    wave0(8, 4);
    check("lock_locked", 32'(locked0), 1);
    check("lock_period", 32'(period0), 8);
    check("lock_pvgap", 32'(pv_gap0), 8);
    check("lock_pvcnt", 32'(n_pv0), 4);
    check("lock_noerr", 32'(n_err0), 0);

    wave0(10, 5);
    check("div10_prev_ok", 32'(locked0), 1);
    wave0(8, 4);
    check("div10_period", 32'(period0), 10);
    check("div10_err", 32'(n_err0), 1);
    check("div10_unlock", 32'(locked0), 0);
    repeat (3) wave0(8, 4);
    check("relock3_locked", 32'(locked0), 0);
    wave0(8, 4);
    check("relock4_locked", 32'(locked0), 1);
    check("relock_err", 32'(n_err0), 1);

    p = n_pv0;
    e = n_err0;
    t = pv_cyc0;
    for (int i = 0; i < 120 && n_err0 == e; i++) @(negedge clk);
    check("tmo_err", 32'(n_err0 - e), 1);
    check("tmo_gap", 32'(err_cyc0 - t), 64);
    check("tmo_unlock", 32'(locked0), 0);
    check("tmo_period", 32'(period0), 8);
    check("tmo_pvcnt", 32'(n_pv0), 32'(p));
    wave0(8, 4);
    check("idle_start_nopv", 32'(n_pv0), 32'(p));
    repeat (4) wave0(8, 4);
    check("idle_relock", 32'(locked0), 1);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_locked", 32'(locked0), 0);
    check("mrst_period", 32'(period0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) wave0(8, 4);
    check("mrst_pre", 32'(locked0), 0);
    wave0(8, 4);
    check("mrst_relock", 32'(locked0), 1);

    e = n_err0;
    d = n_derr0;
    wave0(8, 2);
    check("duty_h4_clean", 32'(n_err0 - e), 0);
    wave0(8, 4);
    check("duty_h2_derr", 32'(n_derr0 - d), 32'(exp_de));
    check("duty_h2_err", 32'(n_err0 - e), 32'(exp_de));
    check("duty_h2_locked", 32'(locked0), 32'(1 - exp_de));

    wave1(7, 3);
    wave1(9, 4);
    wave1(8, 4);
    wave1(7, 3);
    check("tol_pre_locked", 32'(locked1), 0);
    check("tol_pre_pvcnt", 32'(n_pv1), 3);
    wave1(8, 4);
    check("tol_locked", 32'(locked1), 1);
    check("tol_period", 32'(period1), 7);
    check("tol_noerr", 32'(n_err1), 0);
    wave1(6, 3);
    check("tol_keep", 32'(locked1), 1);
    wave1(8, 4);
    check("tol6_period", 32'(period1), 6);
    check("tol6_err", 32'(n_err1), 1);
    check("tol6_unlock", 32'(locked1), 0);
    check("tol_derr", 32'(n_derr1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
